// File: rtl/ika9958_rcc_pkg.sv
// IKA9958_pkg: shared types and cnt4 phase constants for the IKA9958 reset/clock controller.
package IKA9958_pkg;
   typedef enum logic [1:0] {S_RST, S_STRETCH, S_RUN} rcc_state_t;
   localparam logic [1:0] PH_AN0 = 2'd0;
   localparam logic [1:0] PH_AP1 = 2'd1;
   localparam logic [1:0] PH_AN2 = 2'd2;
   localparam logic [1:0] PH_AP3 = 2'd3;
endpackage

// File: rtl/ika9958_rcc_if.sv
// IKA9958_if_rcc: phiA clock, phiA/phiL enable strobes and stretched reset from the RCC.
interface IKA9958_if_rcc;
   logic phiA;
   logic phiA_PCEN;
   logic phiA_NCEN;
   logic phiL_PCEN;
   logic phiL_NCEN;
   logic hrst_n;
   modport drive  (output phiA, phiA_PCEN, phiA_NCEN, phiL_PCEN, phiL_NCEN, hrst_n);
   modport source (input  phiA, phiA_PCEN, phiA_NCEN, phiL_PCEN, phiL_NCEN, hrst_n);
endinterface

// File: rtl/ika9958_rcc_rstseq.sv
// ika9958_rcc_rstseq: reset state machine that holds hrst_n low for RST_STRETCH phiL_NCEN pulses.
module ika9958_rcc_rstseq
   import IKA9958_pkg::*;
#(
   parameter int RST_STRETCH = 16
)(
   input  logic i_EMUCLK,
   input  logic i_HRST_n,
   input  logic phiL_NCEN,
   output logic in_rst,
   output logic hrst_n
);
   localparam int SW = RST_STRETCH > 0 ? $clog2(RST_STRETCH + 1) : 1;
   localparam logic [SW-1:0] S_LAST = SW'(RST_STRETCH > 0 ? RST_STRETCH - 1 : 0);
   rcc_state_t state, state_nx;
   logic [SW-1:0] stcnt;
   always_ff @(posedge i_EMUCLK)
      if (!i_HRST_n) begin
         state <= S_RST;
         stcnt <= '0;
      end else begin
         state <= state_nx;
         if (state == S_STRETCH && phiL_NCEN) stcnt <= stcnt + 1'b1;
      end
   always_comb begin
      state_nx = state;
      if (state == S_RST) state_nx = RST_STRETCH == 0 ? S_RUN : S_STRETCH;
      else if (state == S_STRETCH && phiL_NCEN && stcnt == S_LAST) state_nx = S_RUN;
   end
   assign in_rst = state == S_RST;
   assign hrst_n = state == S_RUN;
endmodule

// File: rtl/ika9958_rcc.sv
// ika9958_rcc: derives phiA/phiL enables, stretched reset and the DHCLK/DLCLK/CPUCLK pin clocks
// from the master clock.
module ika9958_rcc
   import IKA9958_pkg::*;
#(
   parameter int RST_STRETCH = 16,
   parameter int CPUCLK_DIV  = 6
)(
   input  logic         i_EMUCLK,
   input  logic         i_HRST_n,
   IKA9958_if_rcc.drive RCC,
   output logic         o_DHCLK,
   output logic         o_DLCLK,
   output logic         o_CPUCLK
);
   localparam int CW = $clog2(CPUCLK_DIV);
   localparam logic [CW-1:0] C_LAST = CW'(CPUCLK_DIV - 1);
   localparam logic [CW-1:0] C_HALF = CW'(CPUCLK_DIV / 2);
   logic [1:0]    cnt4;
   logic [CW-1:0] cpucnt, cpucnt_nx;
   logic          cpuclk_q, in_rst, phil_ncen;
   assign cpucnt_nx = cpucnt == C_LAST ? '0 : cpucnt + 1'b1;
   always_ff @(posedge i_EMUCLK)
      if (!i_HRST_n) begin
         cnt4     <= PH_AN0;
         cpucnt   <= '0;
         cpuclk_q <= 1'b1;
      end else begin
         cnt4     <= cnt4 + 1'b1;
         cpucnt   <= cpucnt_nx;
         cpuclk_q <= cpucnt_nx < C_HALF;
      end
   // In reset every enable fires so downstream enable-gated registers load their reset values.
   assign phil_ncen      = in_rst | (cnt4 == PH_AP1);
   assign RCC.phiA       = i_EMUCLK;
   assign RCC.phiA_NCEN  = in_rst | (cnt4 == PH_AN0) | (cnt4 == PH_AN2);
   assign RCC.phiA_PCEN  = in_rst | (cnt4 == PH_AP1) | (cnt4 == PH_AP3);
   assign RCC.phiL_NCEN  = phil_ncen;
   assign RCC.phiL_PCEN  = in_rst | (cnt4 == PH_AP3);
   assign o_DHCLK  = ~cnt4[0];
   assign o_DLCLK  = ~cnt4[1];
   assign o_CPUCLK = cpuclk_q;
   ika9958_rcc_rstseq #(.RST_STRETCH(RST_STRETCH)) u_rstseq (
      .i_EMUCLK (i_EMUCLK),
      .i_HRST_n (i_HRST_n),
      .phiL_NCEN(phil_ncen),
      .in_rst   (in_rst),
      .hrst_n   (RCC.hrst_n)
   );
endmodule

// File: tb/tb_ika9958_rcc.sv
// tb_ika9958_rcc: directed checks of reset stretch, enable decodes and pin clocks
// (RST_STRETCH=4 and RST_STRETCH=0 instances share clock and reset).
module tb_ika9958_rcc;
   logic clk = 1'b0;
   logic hrst_n_in = 1'b0;
   logic dh_a, dl_a, cpu_a, dh_b, dl_b, cpu_b;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cur_k = -1;
   IKA9958_if_rcc rcc_a ();
   IKA9958_if_rcc rcc_b ();
   always #5 clk = ~clk;
   ika9958_rcc #(.RST_STRETCH(4), .CPUCLK_DIV(6)) dut_a (
      .i_EMUCLK(clk), .i_HRST_n(hrst_n_in), .RCC(rcc_a),
      .o_DHCLK(dh_a), .o_DLCLK(dl_a), .o_CPUCLK(cpu_a)
   );
   ika9958_rcc #(.RST_STRETCH(0), .CPUCLK_DIV(6)) dut_b (
      .i_EMUCLK(clk), .i_HRST_n(hrst_n_in), .RCC(rcc_b),
      .o_DHCLK(dh_b), .o_DLCLK(dl_b), .o_CPUCLK(cpu_b)
   );
   task automatic chk(input string tag, input logic got, input logic exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s k=%0d got=%b exp=%b", tag, cur_k, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk_reset();
      chk("rst_ancen", rcc_a.phiA_NCEN, 1'b1);
      chk("rst_apcen", rcc_a.phiA_PCEN, 1'b1);
      chk("rst_lncen", rcc_a.phiL_NCEN, 1'b1);
      chk("rst_lpcen", rcc_a.phiL_PCEN, 1'b1);
      chk("rst_hrst", rcc_a.hrst_n, 1'b0);
      chk("rst_dh", dh_a, 1'b1);
      chk("rst_dl", dl_a, 1'b1);
      chk("rst_cpu", cpu_a, 1'b1);
      chk("rst_hrst_b", rcc_b.hrst_n, 1'b0);
   endtask
   // Expected values are written from the cycle index k counted from release.
   task automatic run_chk(input int n);
      for (int k = 0; k < n; k++) begin
         cur_k = k;
         chk("ancen", rcc_a.phiA_NCEN, k % 2 == 0);
         chk("apcen", rcc_a.phiA_PCEN, k == 0 || k % 2 == 1);
         chk("lncen", rcc_a.phiL_NCEN, k == 0 || k % 4 == 1);
         chk("lpcen", rcc_a.phiL_PCEN, k == 0 || k % 4 == 3);
         chk("hrst", rcc_a.hrst_n, k >= 14);
         chk("dh", dh_a, k % 2 == 0);
         chk("dl", dl_a, k % 4 < 2);
         chk("cpu", cpu_a, k % 6 < 3);
         chk("hrst_b", rcc_b.hrst_n, k >= 1);
         chk("ancen_b", rcc_b.phiA_NCEN, k % 2 == 0);
         chk("lncen_b", rcc_b.phiL_NCEN, k == 0 || k % 4 == 1);
         chk("phia", rcc_a.phiA, 1'b1);
         step();
      end
   endtask
   initial begin
      hrst_n_in = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         cur_k = -1;
         chk_reset();
         step();
      end
      hrst_n_in = 1'b1;
      run_chk(7);
      hrst_n_in = 1'b0;
      step();
      cur_k = 8;
      chk_reset();
      hrst_n_in = 1'b1;
      run_chk(20);
      hrst_n_in = 1'b0;
      step();
      cur_k = -2;
      chk_reset();
      hrst_n_in = 1'b1;
      run_chk(16);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
